// File: rtl/control_unit_stage.sv
// ============================================================================
// control_unit_stage
// ID-stage instruction decoder with NOP select mux, plus the EX/MEM control
// register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module control_unit_stage (
  input  logic        clk,
  input  logic        R,
  input  logic [31:0] in_instruction,
  input  logic        S,

  output logic [3:0]  ID_opcode,
  output logic        ID_AM,
  output logic        ID_S_enable,
  output logic        ID_load_instr,
  output logic        ID_RF_enable,
  output logic        ID_Size_enable,
  output logic        ID_RW_enable,
  output logic        ID_Enable_signal,
  output logic        ID_BL_instr,
  output logic        ID_B_instr,

  input  logic        in_EX_load_instr,
  input  logic        in_EX_RF_enable,
  input  logic        in_EX_Size_enable,
  input  logic        in_EX_RW_enable,
  input  logic        in_EX_Enable_signal,

  output logic        MEM_load_instr,
  output logic        MEM_RF_enable,
  output logic        MEM_Size_enable,
  output logic        MEM_RW_enable,
  output logic        MEM_Enable_signal
);

  localparam logic [2:0] CLS_DP_REG  = 3'b000;
  localparam logic [2:0] CLS_DP_IMM  = 3'b001;
  localparam logic [2:0] CLS_LS_IMM  = 3'b010;
  localparam logic [2:0] CLS_LS_REG  = 3'b011;
  localparam logic [2:0] CLS_BRANCH  = 3'b101;

  localparam logic [3:0] OPC_ADD     = 4'b0100;
  localparam logic [3:0] OPC_SUB     = 4'b0010;

  // Raw decoder outputs, before the NOP mux
  logic [3:0] dec_opcode;
  logic       dec_am;
  logic       dec_s_enable;
  logic       dec_load_instr;
  logic       dec_rf_enable;
  logic       dec_size_enable;
  logic       dec_rw_enable;
  logic       dec_enable_signal;
  logic       dec_bl_instr;
  logic       dec_b_instr;

  // The condition field [31:28] never participates in decoding.
  always_comb begin
    dec_opcode        = 4'b0000;
    dec_am            = 1'b0;
    dec_s_enable      = 1'b0;
    dec_load_instr    = 1'b0;
    dec_rf_enable     = 1'b0;
    dec_size_enable   = 1'b0;
    dec_rw_enable     = 1'b0;
    dec_enable_signal = 1'b0;
    dec_bl_instr      = 1'b0;
    dec_b_instr       = 1'b0;

    if (in_instruction != 32'h0000_0000) begin
      case (in_instruction[27:25])
        CLS_DP_REG, CLS_DP_IMM: begin
          dec_opcode    = in_instruction[24:21];
          dec_s_enable  = in_instruction[20];
          dec_am        = in_instruction[25];
          // TST/TEQ/CMP/CMN (10xx) only set flags, never write a register
          dec_rf_enable = (in_instruction[24:23] != 2'b10);
        end
        CLS_LS_IMM, CLS_LS_REG: begin
          dec_opcode        = in_instruction[23] ? OPC_ADD : OPC_SUB;
          dec_am            = ~in_instruction[25];
          dec_load_instr    = in_instruction[20];
          dec_rf_enable     = in_instruction[20];
          dec_size_enable   = in_instruction[22];
          dec_rw_enable     = ~in_instruction[20];
          dec_enable_signal = 1'b1;
        end
        CLS_BRANCH: begin
          dec_b_instr   = 1'b1;
          dec_bl_instr  = in_instruction[24];
          dec_rf_enable = in_instruction[24];
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    if (S) begin
      ID_opcode        = 4'b0000;
      ID_AM            = 1'b0;
      ID_S_enable      = 1'b0;
      ID_load_instr    = 1'b0;
      ID_RF_enable     = 1'b0;
      ID_Size_enable   = 1'b0;
      ID_RW_enable     = 1'b0;
      ID_Enable_signal = 1'b0;
      ID_BL_instr      = 1'b0;
      ID_B_instr       = 1'b0;
    end else begin
      ID_opcode        = dec_opcode;
      ID_AM            = dec_am;
      ID_S_enable      = dec_s_enable;
      ID_load_instr    = dec_load_instr;
      ID_RF_enable     = dec_rf_enable;
      ID_Size_enable   = dec_size_enable;
      ID_RW_enable     = dec_rw_enable;
      ID_Enable_signal = dec_enable_signal;
      ID_BL_instr      = dec_bl_instr;
      ID_B_instr       = dec_b_instr;
    end
  end

  // EX/MEM control register: {load, RF, Size, RW, Enable}
  logic [4:0] mem_d;
  logic [4:0] mem_q;

  assign mem_d = {in_EX_load_instr, in_EX_RF_enable, in_EX_Size_enable,
                  in_EX_RW_enable, in_EX_Enable_signal};

  always_ff @(posedge clk) begin
    if (R) begin
      mem_q <= 5'b00000;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign MEM_load_instr    = mem_q[4];
  assign MEM_RF_enable     = mem_q[3];
  assign MEM_Size_enable   = mem_q[2];
  assign MEM_RW_enable     = mem_q[1];
  assign MEM_Enable_signal = mem_q[0];

endmodule

`default_nettype wire

// File: tb/tb_control_unit_stage.sv
// ============================================================================
// tb_control_unit_stage
// Directed plus randomized checks of the decoder, NOP mux and EX/MEM register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_control_unit_stage;

  logic        clk = 1'b0;
  logic        R   = 1'b0;
  logic [31:0] in_instruction = 32'h0;
  logic        S   = 1'b0;

  logic [3:0]  ID_opcode;
  logic        ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable, ID_Size_enable;
  logic        ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr;

  logic        in_EX_load_instr = 1'b0, in_EX_RF_enable = 1'b0, in_EX_Size_enable = 1'b0;
  logic        in_EX_RW_enable = 1'b0, in_EX_Enable_signal = 1'b0;

  logic        MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable, MEM_Enable_signal;

  int total  = 0;
  int passed = 0;

  control_unit_stage dut (
    .clk                 (clk),
    .R                   (R),
    .in_instruction      (in_instruction),
    .S                   (S),
    .ID_opcode           (ID_opcode),
    .ID_AM               (ID_AM),
    .ID_S_enable         (ID_S_enable),
    .ID_load_instr       (ID_load_instr),
    .ID_RF_enable        (ID_RF_enable),
    .ID_Size_enable      (ID_Size_enable),
    .ID_RW_enable        (ID_RW_enable),
    .ID_Enable_signal    (ID_Enable_signal),
    .ID_BL_instr         (ID_BL_instr),
    .ID_B_instr          (ID_B_instr),
    .in_EX_load_instr    (in_EX_load_instr),
    .in_EX_RF_enable     (in_EX_RF_enable),
    .in_EX_Size_enable   (in_EX_Size_enable),
    .in_EX_RW_enable     (in_EX_RW_enable),
    .in_EX_Enable_signal (in_EX_Enable_signal),
    .MEM_load_instr      (MEM_load_instr),
    .MEM_RF_enable       (MEM_RF_enable),
    .MEM_Size_enable     (MEM_Size_enable),
    .MEM_RW_enable       (MEM_RW_enable),
    .MEM_Enable_signal   (MEM_Enable_signal)
  );

  always #5 clk = ~clk;

  // {opcode, AM, S, load, RF, Size, RW, En, BL, B}
  logic [12:0] id_obs;
  logic [4:0]  mem_obs;
  assign id_obs  = {ID_opcode, ID_AM, ID_S_enable, ID_load_instr, ID_RF_enable,
                    ID_Size_enable, ID_RW_enable, ID_Enable_signal, ID_BL_instr, ID_B_instr};
  assign mem_obs = {MEM_load_instr, MEM_RF_enable, MEM_Size_enable, MEM_RW_enable,
                    MEM_Enable_signal};

  function automatic logic [12:0] pack(input int op, input bit am, input bit s, input bit ld,
                                       input bit rf, input bit sz, input bit rw, input bit en,
                                       input bit bl, input bit b);
    logic [3:0] opv;
    opv = op[3:0];
    return {opv, am, s, ld, rf, sz, rw, en, bl, b};
  endfunction

  // Reference decoder computed from the instruction-class rules
  function automatic logic [12:0] ref_id(input logic [31:0] ins, input logic sel);
    int cls, op;
    bit ibit, ubit, bbit, lbit;
    cls  = int'(ins[27:25]);
    op   = int'(ins[24:21]);
    ibit = ins[25];
    ubit = ins[23];
    bbit = ins[22];
    lbit = ins[20];
    if (sel || ins == 32'd0) return 13'd0;
    if (cls <= 1)
      return pack(op, ibit, ins[20], 0, !(op >= 8 && op <= 11), 0, 0, 0, 0, 0);
    if (cls == 2 || cls == 3)
      return pack(ubit ? 4 : 2, !ibit, 0, lbit, lbit, bbit, !lbit, 1, 0, 0);
    if (cls == 5)
      return pack(0, 0, 0, 0, ins[24], 0, 0, 0, ins[24], 1);
    return 13'd0;
  endfunction

  task automatic check_id(input string tag, input logic [12:0] exp);
    total++;
    assert (id_obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, id_obs, exp);
  endtask

  task automatic check_mem(input string tag, input logic [4:0] exp);
    total++;
    assert (mem_obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, mem_obs, exp);
  endtask

  task automatic set_ex(input logic [4:0] v);
    {in_EX_load_instr, in_EX_RF_enable, in_EX_Size_enable, in_EX_RW_enable,
     in_EX_Enable_signal} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ins;
    logic [4:0]  ex;
    logic [4:0]  mem_exp;
    logic        r;

    // Reset then release
    #1;
    R = 1'b1;
    set_ex(5'b11111);
    tick();
    check_mem("reset_clears", 5'b00000);
    tick();
    check_mem("reset_held", 5'b00000);
    in_instruction = 32'hE082_1003;
    #1;
    check_id("id_ignores_reset", pack(4, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    R = 1'b0;
    #1;
    check_mem("deassert_no_effect", 5'b00000);
    tick();
    check_mem("reset_release_load", 5'b11111);

    // Directed decode vectors
    S = 1'b0;
    in_instruction = 32'hE082_1003; #1;
    check_id("add", pack(4, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    in_instruction = 32'hE591_2004; #1;
    check_id("ldr_imm", pack(4, 1, 0, 1, 1, 0, 0, 1, 0, 0));
    in_instruction = 32'hE153_0004; #1;
    check_id("cmp", pack(10, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    in_instruction = 32'hEB00_0002; #1;
    check_id("bl", pack(0, 0, 0, 0, 1, 0, 0, 0, 1, 1));
    S = 1'b1; #1;
    check_id("bl_nop", 13'd0);
    S = 1'b0;
    in_instruction = 32'h0000_0000; #1;
    check_id("zero_nop", 13'd0);
    in_instruction = 32'hE800_0000; #1;
    check_id("class100_nop", 13'd0);
    in_instruction = 32'h0A00_0010; #1;
    check_id("b_nolink_cond0", pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    in_instruction = 32'hE4C1_2000; #1;
    check_id("strb_post", pack(4, 1, 0, 0, 0, 1, 1, 1, 0, 0));

    // Register path, then inputs changing between edges
    set_ex(5'b11011);
    tick();
    check_mem("ex_mem_load", 5'b11011);
    set_ex(5'b00100);
    #2;
    check_mem("ex_mem_hold_between_edges", 5'b11011);
    tick();
    check_mem("ex_mem_next", 5'b00100);

    // Mid-operation reset discards the captured value
    set_ex(5'b10101);
    R = 1'b1;
    tick();
    check_mem("midop_reset", 5'b00000);
    R = 1'b0;

    // Randomized decoder
    for (int i = 0; i < 300; i++) begin
      ins = $urandom;
      case ($urandom_range(0, 9))
        0: ins = 32'd0;
        1, 2: ins[27:26] = 2'b01;
        3, 4: ins[27:25] = 3'b101;
        5, 6: ins[27:26] = 2'b00;
        default: ;
      endcase
      in_instruction = ins;
      S = ($urandom_range(0, 3) == 0);
      #1;
      check_id($sformatf("rand_id_%0h_s%0b", ins, S), ref_id(ins, S));
    end

    // Randomized EX/MEM register with occasional reset
    mem_exp = mem_obs;
    for (int i = 0; i < 200; i++) begin
      ex = 5'($urandom);
      r  = ($urandom_range(0, 7) == 0);
      set_ex(ex);
      R = r;
      #2;
      check_mem("rand_mem_hold", mem_exp);
      tick();
      mem_exp = r ? 5'b00000 : ex;
      check_mem("rand_mem", mem_exp);
    end
    R = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
